// File: rtl/fib_chk_pkg.sv
// Shared definitions for the Fibonacci stream checker.
//   fib_state_e : checker FSM states (SYNC0 -> SYNC1 -> CHECK)
//   DEF_*       : default parameter values used by the top and the counters
//   ERR_CNT_W   : fixed width of the mismatch counter output
//   MISS_W      : width of the consecutive-miss run register (MAX_MISS <= 15)
package fib_chk_pkg;

  typedef enum logic [1:0] {
    SYNC0 = 2'd0,
    SYNC1 = 2'd1,
    CHECK = 2'd2
  } fib_state_e;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_MAX_MISS = 3;
  localparam int ERR_CNT_W    = 8;
  localparam int MISS_W       = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter shared by the match and mismatch counters.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high clear
//   inc_i : increment request for this cycle
//   cnt_o : current count, holds at all-ones instead of wrapping
module sat_counter
  import fib_chk_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fib_stream_checker.sv
// Locks onto a Fibonacci generator output stream and checks every further
// sample against the sum of the two previously accepted samples.
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   in_valid    : sample strobe (same strobe that advances the generator)
//   in_data     : generator sample
//   resync      : drop the held pair and relock (wins over in_valid)
//   locked      : high while checking
//   mismatch    : one-cycle pulse per rejected sample
//   err_sticky  : set on any mismatch until reset
//   match_count : saturating count of accepted samples
//   err_count   : saturating count of mismatches
//   expect_out  : next expected sample while locked, else 0
module fib_stream_checker
  import fib_chk_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_MISS = DEF_MAX_MISS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 resync,
  output logic                 locked,
  output logic                 mismatch,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     match_count,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [DATA_W-1:0]    expect_out
);

  localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MAX_MISS);

  fib_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [MISS_W-1:0] miss_inc;
  logic              locked_q, locked_d;
  logic              mismatch_q, mismatch_d;
  logic              err_sticky_q, err_sticky_d;
  logic [DATA_W-1:0] expect_q, expect_d;
  logic              match_inc;
  logic              err_inc;

  // Sum formed one bit wider, then the carry is dropped: modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] fib_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    return DATA_W'({1'b0, x} + {1'b0, y});
  endfunction

  assign miss_inc = miss_q + MISS_W'(1);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    miss_d    = miss_q;
    match_inc = 1'b0;
    err_inc   = 1'b0;
    mismatch_d = 1'b0;

    if (resync) begin
      // The pair registers are left as-is; SYNC0/SYNC1 overwrite them.
      state_d = SYNC0;
      miss_d  = '0;
    end else if (in_valid) begin
      case (state_q)
        SYNC0: begin
          a_d     = in_data;
          state_d = SYNC1;
        end
        SYNC1: begin
          b_d     = in_data;
          state_d = CHECK;
        end
        CHECK: begin
          if (in_data == fib_add(a_q, b_q)) begin
            a_d       = b_q;
            b_d       = in_data;
            match_inc = 1'b1;
            miss_d    = '0;
          end else begin
            mismatch_d = 1'b1;
            err_inc    = 1'b1;
            // The rejected sample is never reused as a seed after dropping lock.
            if (miss_inc == MISS_LIM) begin
              state_d = SYNC0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = SYNC0;
      endcase
    end

    locked_d     = (state_d == CHECK);
    err_sticky_d = err_sticky_q | mismatch_d;
    expect_d     = (state_d == CHECK) ? fib_add(a_d, b_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SYNC0;
      a_q          <= '0;
      b_q          <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      expect_q     <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      expect_q     <= expect_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (match_inc),
    .cnt_o (match_count)
  );

  sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (err_inc),
    .cnt_o (err_count)
  );

  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign expect_out = expect_q;

endmodule
